// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// rx_valid is a one-cycle strobe with no ready: a byte is taken in every cycle it is high.
// imem_we is a one-cycle write pulse; imem_addr/imem_wdata are stable while it is high.
interface program_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs a length-prefixed big-endian byte stream into instruction memory, then releases
// the core from reset. Define LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte before DONE.
module program_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    program_loader_if.slave   bus,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        state_dbg
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR, S_CSUM} state_t;
    localparam state_t S_AFTER = S_CSUM;
`else
    typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER = S_DONE;
`endif

    localparam logic [CNT_W:0] CAP = {{(CNT_W-ADDR_W){1'b0}}, 1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [CNT_W-1:0]  len, len_n, hdr_full;
    logic [31:0]       shreg, shreg_n, word_full;
    logic              we_r, we_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [31:0]       wdata_r, wdata_n;
    logic [ADDR_W:0]   words_n, words_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum, sum_n;
`endif

    assign bus.imem_we    = we_r;
    assign bus.imem_addr  = addr_r;
    assign bus.imem_wdata = wdata_r;
    assign state_dbg      = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_HDR;
            byte_cnt     <= 2'd0;
            len          <= '0;
            shreg        <= '0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rst      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum          <= 8'd0;
`endif
        end else begin
            state        <= state_n;
            byte_cnt     <= byte_cnt_n;
            len          <= len_n;
            shreg        <= shreg_n;
            we_r         <= we_n;
            addr_r       <= addr_n;
            wdata_r      <= wdata_n;
            words_loaded <= words_n;
            done         <= done | (state_n == S_DONE);
            err          <= err | (state_n == S_ERR);
            // Lags done by one cycle so the core sees a clean release after the last write.
            cpu_rst      <= ~done;
`ifdef LOADER_CHECKSUM_EN
            sum          <= sum_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        len_n      = len;
        shreg_n    = shreg;
        we_n       = 1'b0;
        addr_n     = addr_r;
        wdata_n    = wdata_r;
        words_n    = words_loaded;
`ifdef LOADER_CHECKSUM_EN
        sum_n      = sum;
`endif
        hdr_full   = {len[CNT_W-9:0], bus.rx_data};
        word_full  = {shreg[23:0], bus.rx_data};
        words_inc  = words_loaded + 1'b1;
        case (state)
            S_HDR: begin
                if (bus.rx_valid) begin
                    len_n      = hdr_full;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (hdr_full == '0)
                            state_n = S_AFTER;
                        else if ({1'b0, hdr_full} > CAP)
                            state_n = S_ERR;
                        else
                            state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    shreg_n    = word_full;
                    byte_cnt_n = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_n      = sum + bus.rx_data;
`endif
                    if (byte_cnt == 2'd3) begin
                        we_n    = 1'b1;
                        wdata_n = word_full;
                        addr_n  = words_loaded[ADDR_W-1:0];
                        words_n = words_inc;
                        if ({{(CNT_W-ADDR_W-1){1'b0}}, words_inc} == len)
                            state_n = S_AFTER;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (bus.rx_valid)
                    state_n = (bus.rx_data == sum) ? S_DONE : S_ERR;
            end
`endif
            default: ;
        endcase
    end
endmodule
